// File: rtl/scan_chain_ctrl.sv
// rtl/scan_chain_ctrl.sv - scan transaction sequencer driving a two-phase scan clock generator
// Optional SOut capture into RData is enabled by defining SCAN_CHAIN_CTRL_READBACK_EN.
module scan_chain_ctrl #(
  parameter int MAX_BITS = 256,
  parameter int LEN_W    = $clog2(MAX_BITS + 1)
) (
  input  logic                RefClk,
  input  logic                ResetN,
  input  logic                Start,
  input  logic [LEN_W-1:0]    Len,
  input  logic [MAX_BITS-1:0] WData,
  input  logic                Abort,
  input  logic                SOut,
  output logic                Ready,
  output logic                ClkEn,
  output logic                SIn,
  output logic                ScanUpdate,
  output logic                Done,
  output logic                Aborted,
  output logic [MAX_BITS-1:0] RData
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_UPDATE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_BITS);

  logic [1:0]          state_q, state_d;
  logic [1:0]          phase_q, phase_d;
  logic [LEN_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [MAX_BITS-1:0] wdata_q, wdata_d;
  logic                abort_q, abort_d;
  logic                ready_q, ready_d;
  logic                clk_en_q, clk_en_d;
  logic                sin_q, sin_d;
  logic                update_q, update_d;
  logic                done_q, done_d;
  logic                aborted_q, aborted_d;

  logic [LEN_W-1:0]    len_clamp;
  logic [LEN_W-1:0]    bit_cnt_inc;
  logic                last_bit;
  logic                stop_req;
  logic                accept;

  assign accept      = (state_q == ST_IDLE) && Start && ready_q;
  assign len_clamp   = (Len > LEN_MAX) ? LEN_MAX : Len;
  assign bit_cnt_inc = bit_cnt_q + LEN_W'(1);
  assign last_bit    = (bit_cnt_inc == len_q);
  // An abort seen on the closing edge of a group still ends at that group.
  assign stop_req    = abort_q | Abort;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_cnt_d = bit_cnt_q;
    len_d     = len_q;
    wdata_d   = wdata_q;
    abort_d   = abort_q;
    ready_d   = ready_q;
    clk_en_d  = clk_en_q;
    sin_d     = sin_q;
    update_d  = 1'b0;
    done_d    = 1'b0;
    aborted_d = aborted_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          len_d     = len_clamp;
          wdata_d   = WData;
          sin_d     = WData[0];
          phase_d   = 2'd0;
          bit_cnt_d = '0;
          abort_d   = 1'b0;
          aborted_d = 1'b0;
          ready_d   = 1'b0;
          if (len_clamp == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d  = ST_SHIFT;
            clk_en_d = 1'b1;
          end
        end
      end

      ST_SHIFT: begin
        phase_d = phase_q + 2'd1;
        if (Abort) begin
          abort_d = 1'b1;
        end
        // Only the edge leaving phase 3 may end the shift, keeping the generator in its reset phase.
        if (phase_q == 2'd3) begin
          bit_cnt_d = bit_cnt_inc;
          wdata_d   = wdata_q >> 1;
          if (stop_req) begin
            state_d   = ST_DONE;
            clk_en_d  = 1'b0;
            sin_d     = 1'b0;
            done_d    = 1'b1;
            aborted_d = 1'b1;
          end else if (last_bit) begin
            state_d  = ST_UPDATE;
            clk_en_d = 1'b0;
            sin_d    = 1'b0;
            update_d = 1'b1;
          end else begin
            sin_d = wdata_q[1];
          end
        end
      end

      ST_UPDATE: begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge RefClk or negedge ResetN) begin
    if (!ResetN) begin
      state_q   <= ST_IDLE;
      phase_q   <= 2'd0;
      bit_cnt_q <= '0;
      len_q     <= '0;
      wdata_q   <= '0;
      abort_q   <= 1'b0;
      ready_q   <= 1'b1;
      clk_en_q  <= 1'b0;
      sin_q     <= 1'b0;
      update_q  <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_cnt_q <= bit_cnt_d;
      len_q     <= len_d;
      wdata_q   <= wdata_d;
      abort_q   <= abort_d;
      ready_q   <= ready_d;
      clk_en_q  <= clk_en_d;
      sin_q     <= sin_d;
      update_q  <= update_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

`ifdef SCAN_CHAIN_CTRL_READBACK_EN
  logic [MAX_BITS-1:0] rdata_q, rdata_d;

  // SOut is sampled on the edge leaving phase 1, before the slave latches move the chain.
  always_comb begin
    rdata_d = rdata_q;
    if (accept) begin
      rdata_d = '0;
    end else if ((state_q == ST_SHIFT) && (phase_q == 2'd1)) begin
      for (int i = 0; i < MAX_BITS; i++) begin
        if (bit_cnt_q == LEN_W'(i)) begin
          rdata_d[i] = SOut;
        end
      end
    end
  end

  always_ff @(posedge RefClk or negedge ResetN) begin
    if (!ResetN) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign RData = rdata_q;
`else
  logic unused_sout;

  assign unused_sout = SOut;
  assign RData       = '0;
`endif

  assign Ready      = ready_q;
  assign ClkEn      = clk_en_q;
  assign SIn        = sin_q;
  assign ScanUpdate = update_q;
  assign Done       = done_q;
  assign Aborted    = aborted_q;

endmodule
